// File: rtl/chip8_mem_arbiter.sv
// rtl/chip8_mem_arbiter.sv - N-channel request arbiter in front of the CHIP-8 unified memory port A
module chip8_mem_arbiter #(
  parameter int                              NUM_CH        = 4,
  parameter int                              DATA_WIDTH    = 8,
  parameter int                              ADDR_WIDTH    = 13,
  parameter logic [NUM_CH*ADDR_WIDTH-1:0]    CH_BASE       = '0,
  parameter int                              READ_LATENCY  = 2,
  parameter int                              PRIORITY_MODE = 0
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_CH-1:0]            req_valid_in,
  output logic [NUM_CH-1:0]            req_ready_out,
  input  logic [NUM_CH-1:0]            req_we_in,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] req_addr_in,
  input  logic [NUM_CH*DATA_WIDTH-1:0] req_data_in,
  output logic [NUM_CH-1:0]            rsp_valid_out,
  output logic [DATA_WIDTH-1:0]        rsp_data_out,
  output logic                         mem_en_out,
  output logic                         mem_we_out,
  output logic [ADDR_WIDTH-1:0]        mem_addr_out,
  output logic [DATA_WIDTH-1:0]        mem_data_out,
  input  logic [DATA_WIDTH-1:0]        mem_data_in
);

  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0]     held_q, held_d;
  logic [NUM_CH-1:0]     hwe_q, hwe_d;
  logic [ADDR_WIDTH-1:0] haddr_q [NUM_CH];
  logic [ADDR_WIDTH-1:0] haddr_d [NUM_CH];
  logic [DATA_WIDTH-1:0] hdata_q [NUM_CH];
  logic [DATA_WIDTH-1:0] hdata_d [NUM_CH];

  logic [CW-1:0]         ptr_q, ptr_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [CW-1:0]         issue_ch_q, issue_ch_d;

  logic                  tag_v_q  [READ_LATENCY];
  logic [CW-1:0]         tag_ch_q [READ_LATENCY];

  logic [ADDR_WIDTH-1:0] base_w     [NUM_CH];
  logic [ADDR_WIDTH-1:0] req_addr_w [NUM_CH];
  logic [DATA_WIDTH-1:0] req_data_w [NUM_CH];

  logic                  grant_vld;
  logic [CW-1:0]         grant_idx;
  logic [NUM_CH-1:0]     grant_vec;
  logic [NUM_CH-1:0]     accept;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_unpack
    assign base_w[c]     = CH_BASE[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_addr_w[c] = req_addr_in[c*ADDR_WIDTH +: ADDR_WIDTH];
    assign req_data_w[c] = req_data_in[c*DATA_WIDTH +: DATA_WIDTH];
  end

  // Later loop iterations overwrite earlier ones, so iterate from lowest to highest precedence.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_idx = '0;
    if (PRIORITY_MODE != 0) begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (held_q[i]) begin
          grant_vld = 1'b1;
          grant_idx = CW'(i);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        idx = (int'(ptr_q) + k) % NUM_CH;
        if (held_q[idx]) begin
          grant_vld = 1'b1;
          grant_idx = CW'(idx);
        end
      end
    end
    grant_vec = grant_vld ? (NUM_CH'(1) << grant_idx) : '0;
  end

  // A granted channel re-arms in the same cycle so an uncontended channel sustains one request per cycle.
  assign req_ready_out = {NUM_CH{~rst_in}} & (~held_q | grant_vec);
  assign accept        = req_valid_in & req_ready_out;

  always_comb begin
    held_d  = held_q;
    hwe_d   = hwe_q;
    haddr_d = haddr_q;
    hdata_d = hdata_q;
    for (int c = 0; c < NUM_CH; c++) begin
      if (accept[c]) begin
        held_d[c]  = 1'b1;
        hwe_d[c]   = req_we_in[c];
        haddr_d[c] = req_addr_w[c];
        hdata_d[c] = req_data_w[c];
      end else if (grant_vec[c]) begin
        held_d[c] = 1'b0;
      end
    end
  end

  always_comb begin
    ptr_d      = ptr_q;
    mem_en_d   = grant_vld;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    issue_ch_d = issue_ch_q;
    if (grant_vld) begin
      mem_we_d   = hwe_q[grant_idx];
      mem_addr_d = base_w[grant_idx] + haddr_q[grant_idx];
      mem_data_d = hdata_q[grant_idx];
      issue_ch_d = grant_idx;
      if (PRIORITY_MODE == 0) begin
        ptr_d = grant_idx;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      held_q     <= '0;
      hwe_q      <= '0;
      ptr_q      <= CW'(NUM_CH - 1);
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      issue_ch_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        haddr_q[c] <= '0;
        hdata_q[c] <= '0;
      end
    end else begin
      held_q     <= held_d;
      hwe_q      <= hwe_d;
      ptr_q      <= ptr_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      issue_ch_q <= issue_ch_d;
      for (int c = 0; c < NUM_CH; c++) begin
        haddr_q[c] <= haddr_d[c];
        hdata_q[c] <= hdata_d[c];
      end
    end
  end

  // Tag stage 0 loads from the issue register, so the last stage lines up with mem_data_in.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        tag_v_q[i]  <= 1'b0;
        tag_ch_q[i] <= '0;
      end
    end else begin
      tag_v_q[0]  <= mem_en_q;
      tag_ch_q[0] <= issue_ch_q;
      for (int i = 1; i < READ_LATENCY; i++) begin
        tag_v_q[i]  <= tag_v_q[i-1];
        tag_ch_q[i] <= tag_ch_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_valid_out = '0;
    if (tag_v_q[READ_LATENCY-1]) begin
      rsp_valid_out[tag_ch_q[READ_LATENCY-1]] = 1'b1;
    end
  end

  assign rsp_data_out = mem_data_in;
  assign mem_en_out   = mem_en_q;
  assign mem_we_out   = mem_we_q;
  assign mem_addr_out = mem_addr_q;
  assign mem_data_out = mem_data_q;

endmodule
